// File: rtl/shared_reg_arbiter.sv
// Two-requester round-robin arbiter that owns one shared W-bit enabled register.
// The owner's strobe and data are forwarded as the register enable and D input.
// A waiting requester takes over after a bounded burst.
module shared_reg_arbiter #(
  parameter int W         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [1:0]   wr,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [1:0]   gnt,
  output logic         reg_en,
  output logic [W-1:0] reg_d,
  output logic [W-1:0] q
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t         state_q;
  logic           last_q;
  logic [3:0]     cnt_q;
  logic [1:0]     gnt_q;
  logic [W-1:0]   q_q, q_d;
  logic           own_idx, oth_idx, idle_pick;

  function automatic state_t own_st(input logic i);
    return i ? OWN1 : OWN0;
  endfunction

  function automatic logic [1:0] onehot(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  // Register write path: only the current owner's strobe reaches the register.
  always_comb begin
    reg_en = |(gnt_q & wr);
    reg_d  = '0;
    if (gnt_q[0])      reg_d = d0;
    else if (gnt_q[1]) reg_d = d1;
    q_d = reg_en ? reg_d : q_q;
  end

  // Owner/other indices and the IDLE pick (tie goes to the one that was not last).
  always_comb begin
    own_idx   = (state_q == OWN1);
    oth_idx   = ~own_idx;
    idle_pick = (req == 2'b11) ? ~last_q : req[1];
  end

  // Arbitration FSM with registered grant, last-owner and burst counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            state_q <= own_st(idle_pick);
            gnt_q   <= onehot(idle_pick);
            cnt_q   <= 4'd0;
          end
        end
        OWN0, OWN1: begin
          if (!req[own_idx]) begin
            // Owner released: hand straight over if the other side waits.
            state_q <= req[oth_idx] ? own_st(oth_idx) : IDLE;
            gnt_q   <= req[oth_idx] ? onehot(oth_idx) : 2'b00;
            last_q  <= own_idx;
            cnt_q   <= 4'd0;
          end else if (req[oth_idx] && cnt_q == CNT_MAX) begin
            // Burst exhausted with the other side waiting: preempt.
            state_q <= own_st(oth_idx);
            gnt_q   <= onehot(oth_idx);
            last_q  <= own_idx;
            cnt_q   <= 4'd0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Shared register contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign gnt = gnt_q;
  assign q   = q_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: a driver advances an ownership model
// and queues expectations; two monitors pop and compare against the DUT.
module tb_shared_reg_arbiter;
  localparam int W  = 4;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req, wr;
  logic [W-1:0] d0, d1;
  logic [1:0]   gnt;
  logic         reg_en;
  logic [W-1:0] reg_d, q;

  shared_reg_arbiter #(.W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .d0(d0), .d1(d1),
    .gnt(gnt), .reg_en(reg_en), .reg_d(reg_d), .q(q)
  );

  always #5 clk = ~clk;

  typedef struct { logic en; logic [W-1:0] d; } comb_t;
  typedef struct { logic [1:0] g; logic [W-1:0] q; } seq_t;
  comb_t comb_q[$];
  seq_t  seq_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the register, how long they have held it,
  // who owned it last, and what the register holds.
  int         m_own;
  bit         m_last;
  int         m_run;
  logic [W-1:0] m_q;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_last = 1'b1; m_run = 0; m_q = '0;
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] w,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    comb_t c; seq_t s; int o;
    @(negedge clk);
    req = r; wr = w; d0 = a; d1 = b;
    c.en = 1'b0; c.d = '0;
    if (m_own == 0) begin c.en = w[0]; c.d = a; end
    if (m_own == 1) begin c.en = w[1]; c.d = b; end
    comb_q.push_back(c);
    if (c.en) m_q = c.d;
    if (m_own < 0) begin
      if (r == 2'b11)      begin m_own = m_last ? 0 : 1; m_run = 1; end
      else if (r != 2'b00) begin m_own = r[1] ? 1 : 0;   m_run = 1; end
    end else begin
      o = 1 - m_own;
      if (!r[m_own]) begin
        m_last = (m_own == 1);
        m_own  = r[o] ? o : -1;
        m_run  = 1;
      end else if (r[o] && m_run >= MB) begin
        m_last = (m_own == 1);
        m_own  = o;
        m_run  = 1;
      end else if (m_run < MB) begin
        m_run++;
      end
    end
    s.g = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    s.q = m_q;
    seq_q.push_back(s);
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before any edge.
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_q", 8'(q), 8'h0);
    chk("rst_en", 8'(reg_en), 8'h0);
    chk("rst_d", 8'(reg_d), 8'h0);
    model_reset();
    #1 reset = 1'b0;
  endtask

  // Monitor for the combinational register inputs.
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("reg_en", 8'(reg_en), 8'(c.en));
        chk("reg_d", 8'(reg_d), 8'(c.d));
      end
    end
  end

  // Monitor for the registered outputs after each edge.
  initial begin
    seq_t s;
    forever begin
      @(posedge clk);
      #1;
      if (seq_q.size() > 0) begin
        s = seq_q.pop_front();
        chk("gnt", 8'(gnt), 8'(s.g));
        chk("q", 8'(q), 8'(s.q));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] r;
    req = '0; wr = '0; d0 = '0; d1 = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("init_gnt", 8'(gnt), 8'h0);
    chk("init_q", 8'(q), 8'h0);
    #1 reset = 1'b0;

    // Load 1010, then reset mid-cycle.
    step(2'b01, 2'b00, 4'b1010, 4'h0);
    step(2'b01, 2'b01, 4'b1010, 4'h0);
    step(2'b00, 2'b00, 4'h0, 4'h0);
    do_reset();

    // Writes in IDLE are ignored.
    repeat (4) step(2'b00, 2'b11, 4'hf, 4'hf);

    // Single requester write and release.
    repeat (2) step(2'b01, 2'b01, 4'b1100, 4'h0);
    step(2'b00, 2'b00, 4'h0, 4'h0);

    // Tie after reset, release handoff, later tie from IDLE.
    do_reset();
    repeat (2) step(2'b11, 2'b00, 4'h0, 4'h0);
    step(2'b10, 2'b00, 4'h0, 4'h0);
    step(2'b00, 2'b00, 4'h0, 4'h0);
    step(2'b11, 2'b00, 4'h0, 4'h0);
    step(2'b00, 2'b00, 4'h0, 4'h0);

    // Preemption under continuous contention.
    repeat (10) step(2'b11, 2'b11, 4'b0011, 4'b1111);
    step(2'b00, 2'b00, 4'h0, 4'h0);

    // Non-owner write ignored.
    step(2'b01, 2'b00, 4'h0, 4'h0);
    repeat (2) step(2'b11, 2'b10, 4'h0, 4'b0101);
    step(2'b00, 2'b00, 4'h0, 4'h0);

    // Reset during OWN1 with a write pending, then resume.
    repeat (3) step(2'b10, 2'b10, 4'h0, 4'b1001);
    do_reset();
    repeat (3) step(2'b10, 2'b10, 4'h0, 4'b0110);
    step(2'b11, 2'b11, 4'h3, 4'h5);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11 & {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
      step(r, 2'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    repeat (3) @(posedge clk);
    #2;
    chk("comb_q_empty", 8'(comb_q.size()), 8'h0);
    chk("seq_q_empty", 8'(seq_q.size()), 8'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
